// File: rtl/aes_key_expand_if.sv
// Round-key stream from the key-schedule engine to the cipher round datapath.
interface aes_key_expand_if;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;

  modport master (output rk_valid, rk_idx, rk_data, input rk_ready);
  modport slave  (input rk_valid, rk_idx, rk_data, output rk_ready);
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128/192/256 key schedule: one expanded word per cycle,
// round keys streamed out as 128-bit beats with valid/ready backpressure.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | expanding words and streaming round keys
// S_DONE | last round key accepted; returns to idle next cycle

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] b;
    p = 8'h00;
    b = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ b;
      b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

  // Multiplicative inverse as a^254, then the affine transform.
  always_comb begin
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    inv  = gmul(gmul(x240, x12), x2);
    s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_expand (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       key_len,
  input  logic [255:0]     key_in,
  output logic             busy,
  output logic             done,
  aes_key_expand_if.master rk
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t       state, state_nx;
  logic [255:0] key_sh;
  logic [31:0]  win [8];
  logic [5:0]   i;
  logic [2:0]   phase;
  logic [2:0]   nk_m1;
  logic [3:0]   nr;
  logic [7:0]   rcon;
  logic [95:0]  asm_buf;
  logic [1:0]   asm_cnt;

  logic [5:0]   nw;
  logic         hs, word_ok, key_phase;
  logic [31:0]  prev, old, sub_in, sub_out, w_new;

  assign nw        = {nr + 4'd1, 2'b00};
  assign hs        = rk.rk_valid && rk.rk_ready;
  assign word_ok   = (state == S_RUN) && (i < nw) && (!rk.rk_valid || rk.rk_ready);
  assign key_phase = (i <= {3'b000, nk_m1});
  assign prev      = win[0];
  assign old       = win[nk_m1];
  assign sub_in    = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a(sub_in[8*g +: 8]), .s(sub_out[8*g +: 8]));
  end

  always_comb begin
    w_new = old ^ prev;
    if (key_phase)
      w_new = key_sh[255:224];
    else if (phase == 3'd0)
      w_new = old ^ sub_out ^ {rcon, 24'h000000};
    else if (nk_m1 == 3'd7 && phase == 3'd4)
      w_new = old ^ sub_out;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_RUN;
      S_RUN:  if (hs && rk.rk_idx == nr) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      key_sh     <= '0;
      for (int k = 0; k < 8; k++) win[k] <= '0;
      i          <= '0;
      phase      <= '0;
      nk_m1      <= 3'd3;
      nr         <= 4'd10;
      rcon       <= 8'h01;
      asm_buf    <= '0;
      asm_cnt    <= '0;
      rk.rk_valid <= 1'b0;
      rk.rk_idx   <= '0;
      rk.rk_data  <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != S_IDLE);
      done  <= (state == S_DONE);

      if (state == S_IDLE && start) begin
        key_sh    <= key_in;
        i         <= '0;
        phase     <= '0;
        rcon      <= 8'h01;
        asm_cnt   <= '0;
        rk.rk_idx <= '0;
        case (key_len)
          2'b01:   begin nk_m1 <= 3'd5; nr <= 4'd12; end
          2'b10:   begin nk_m1 <= 3'd7; nr <= 4'd14; end
          default: begin nk_m1 <= 3'd3; nr <= 4'd10; end
        endcase
      end

      if (word_ok) begin
        for (int k = 7; k > 0; k--) win[k] <= win[k-1];
        win[0]  <= w_new;
        key_sh  <= {key_sh[223:0], 32'h0};
        i       <= i + 6'd1;
        phase   <= (phase == nk_m1) ? 3'd0 : phase + 3'd1;
        if (!key_phase && phase == 3'd0)
          rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        asm_cnt <= asm_cnt + 2'd1;
        asm_buf <= {asm_buf[63:0], w_new};
        if (asm_cnt == 2'd3) rk.rk_data <= {asm_buf, w_new};
      end

      // A 4th word written in a handshake cycle keeps valid high with no bubble.
      if (word_ok && asm_cnt == 2'd3)
        rk.rk_valid <= 1'b1;
      else if (hs)
        rk.rk_valid <= 1'b0;

      if (hs) rk.rk_idx <= rk.rk_idx + 4'd1;
    end
  end
endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 vectors, timing, backpressure, restart/reset
// and random keys against a table-driven key-schedule model.
module tb_aes_key_expand;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy, done;

  aes_key_expand_if rk();

  aes_key_expand dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len),
    .key_in(key_in), .busy(busy), .done(done), .rk(rk)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c00000000000000000000000000000000;
  localparam logic [255:0] K192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b0000000000000000;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [79:0] RCON = 80'h01020408102040801b36;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
  endfunction

  logic [31:0] mw [60];

  task automatic model(input logic [1:0] kl, input logic [255:0] key, output int nr);
    int nk;
    logic [31:0] t;
    nk = (kl == 2'd1) ? 6 : (kl == 2'd2) ? 8 : 4;
    nr = nk + 6;
    for (int j = 0; j < nk; j++) mw[j] = key[255 - 32*j -: 32];
    for (int j = nk; j < 4*(nr+1); j++) begin
      t = mw[j-1];
      if (j % nk == 0)
        t = subw({t[23:0], t[31:24]}) ^ {RCON[79 - 8*(j/nk - 1) -: 8], 24'h0};
      else if (nk == 8 && j % 8 == 4)
        t = subw(t);
      mw[j] = mw[j-nk] ^ t;
    end
  endtask

  // ---------------- run collector ----------------
  logic [127:0] got_d [16];
  logic [3:0]   got_i [16];
  logic [127:0] gall  [48];
  int nbeats, first_v, done_cnt, done_n, last_hs_n, stall_bad;

  task automatic run_exp(input logic [1:0] kl, input logic [255:0] key, input int rdy_pct,
                         input int restart_n, input int reset_after);
    logic         prev_stall;
    logic [127:0] pd;
    logic [3:0]   pi;
    int           n;
    bit           stop;
    nbeats = 0; first_v = -1; done_cnt = 0; done_n = -1; last_hs_n = -1; stall_bad = 0;
    prev_stall = 1'b0; pd = '0; pi = '0; stop = 1'b0;
    @(negedge clk);
    start = 1'b1; key_len = kl; key_in = key;
    @(posedge clk);
    n = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      key_in = {8{$urandom}};
      key_len = 2'($urandom);
      if (prev_stall && (!rk.rk_valid || rk.rk_data !== pd || rk.rk_idx !== pi)) stall_bad++;
      if (rk.rk_valid && first_v < 0) first_v = n;
      if (done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (done_n >= 0 && n >= done_n + 3) begin
        stop = 1'b1;
        break;
      end
      rk.rk_ready = ($urandom_range(99) < rdy_pct);
      if (n == restart_n) begin
        start = 1'b1; key_len = 2'd2; key_in = ~key;
      end
      if (rk.rk_valid && rk.rk_ready) begin
        if (nbeats < 16) begin
          got_d[nbeats] = rk.rk_data;
          got_i[nbeats] = rk.rk_idx;
        end
        nbeats++;
        last_hs_n = n;
      end
      prev_stall = rk.rk_valid && !rk.rk_ready;
      pd = rk.rk_data;
      pi = rk.rk_idx;
      if (reset_after > 0 && nbeats == reset_after) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {125'h0, busy, rk.rk_valid, done}, 128'h0);
        check("async_reset_data", rk.rk_data, 128'h0);
        check("async_reset_idx", {124'h0, rk.rk_idx}, 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stop = 1'b1;
        break;
      end
      @(posedge clk);
      n++;
    end
    if (!stop) begin
      total++; bad++;
      $display("FAIL run_timeout: got no done within bound, beats=%0d", nbeats);
    end
  endtask

  task automatic verify_run(input logic [1:0] kl, input logic [255:0] key, input string tag);
    int nr;
    model(kl, key, nr);
    check({tag, "_beats"}, 128'(nbeats), 128'(nr + 1));
    for (int k = 0; k < nbeats && k <= nr && k < 16; k++) begin
      check($sformatf("%s_rk%0d", tag, k), got_d[k], {mw[4*k], mw[4*k+1], mw[4*k+2], mw[4*k+3]});
      check($sformatf("%s_idx%0d", tag, k), {124'h0, got_i[k]}, 128'(k));
    end
    check({tag, "_stall_stable"}, 128'(stall_bad), 128'h0);
    check({tag, "_done_pulses"}, 128'(done_cnt), 128'h1);
  endtask

  typedef struct {
    string        name;
    logic [1:0]   kl;
    int           idx;
    logic [127:0] mask;
    logic [127:0] exp;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [1:0]   rkl;
    logic [255:0] rkey;
    int           pct;

    vt[0] = '{"a1_rk0",  2'd0, 0,  {128{1'b1}}, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    vt[1] = '{"a1_rk1",  2'd0, 1,  {128{1'b1}}, 128'ha0fafe1788542cb123a339392a6c7605};
    vt[2] = '{"a1_rk10", 2'd0, 10, {128{1'b1}}, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vt[3] = '{"a2_rk1w", 2'd1, 1,  128'h0000000000000000ffffffff00000000,
              128'h0000000000000000fe0c91f700000000};
    vt[4] = '{"a2_rk12", 2'd1, 12, {128{1'b1}}, 128'he98ba06f448c773c8ecc720401002202};
    vt[5] = '{"a3_rk14", 2'd2, 14, {128{1'b1}}, 128'hfe4890d1e6188d0b046df344706c631e};

    rst_n = 1'b0; start = 1'b0; key_len = 2'd0; key_in = '0; rk.rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {125'h0, busy, rk.rk_valid, done}, 128'h0);
    check("reset_idx", {124'h0, rk.rk_idx}, 128'h0);
    check("reset_data", rk.rk_data, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ctrl", {125'h0, busy, rk.rk_valid, done}, 128'h0);

    // FIPS-197 vectors with ready tied high, collected for the table check
    for (int kl = 0; kl < 3; kl++) begin
      rkey = (kl == 0) ? K128 : (kl == 1) ? K192 : K256;
      run_exp(2'(kl), rkey, 100, -1, 0);
      for (int k = 0; k < 16; k++) gall[kl*16 + k] = got_d[k];
      verify_run(2'(kl), rkey, $sformatf("fips%0d", kl));
      if (kl == 0) begin
        check("t128_first_valid", 128'(first_v), 128'd4);
        check("t128_last_hs", 128'(last_hs_n), 128'd44);
        check("t128_done_delay", 128'(done_n), 128'(last_hs_n + 2));
      end
    end
    for (int v = 0; v < 6; v++)
      check(vt[v].name, gall[int'(vt[v].kl)*16 + vt[v].idx] & vt[v].mask, vt[v].exp);

    // backpressure: ready high ~30% of cycles
    run_exp(2'd0, K128, 30, -1, 0);
    verify_run(2'd0, K128, "bp128");

    // start while busy with a different key must be ignored
    run_exp(2'd0, K128, 100, 10, 0);
    verify_run(2'd0, K128, "restart");

    // reset after rk3 handshake, then a clean rerun
    run_exp(2'd0, K128, 100, -1, 4);
    @(negedge clk);
    check("post_reset_ctrl", {125'h0, busy, rk.rk_valid, done}, 128'h0);
    run_exp(2'd0, K128, 100, -1, 0);
    verify_run(2'd0, K128, "after_rst");

    // random keys, lengths and backpressure
    for (int r = 0; r < 4; r++) begin
      rkl  = 2'($urandom_range(3));
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pct  = $urandom_range(100, 25);
      run_exp(rkl, rkey, pct, -1, 0);
      verify_run(rkl, rkey, $sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
